// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg: shared state encoding, SYNC pattern and J/K line levels for USB TX.
// Revision: 1.0
// ============================================================================
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } usb_tx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  // {D+, D-} for each idle/differential level
  localparam logic [1:0] FS_J     = 2'b10;
  localparam logic [1:0] FS_K     = 2'b01;
  localparam logic [1:0] LS_J     = 2'b01;
  localparam logic [1:0] LS_K     = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] line_code(input logic ls, input logic k);
    if (k) return ls ? LS_K : FS_K;
    return ls ? LS_J : FS_J;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_tx_if.sv
`default_nettype none
// ============================================================================
// usb_nrzi_tx_if: per-bit valid/ready stream from the packet serialiser.
// Revision: 1.0
// ============================================================================
interface usb_nrzi_tx_if;
  logic bit_in;
  logic bit_last;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_in, output bit_last, output bit_valid, input  bit_ready);
  modport slave  (input  bit_in, input  bit_last, input  bit_valid, output bit_ready);
endinterface
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// flex_counter: up-counter wrapping to zero after rollover_val; clear wins.
// Revision: 1.0
// ============================================================================
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_nrzi_tx.sv
`default_nettype none
// ============================================================================
// usb_nrzi_tx: USB NRZI line encoder with bit stuffing and SE0/J end-of-packet.
// Define USB_TX_SYNC_EN to prepend the 8-bit SYNC pattern in hardware.
// Revision: 1.0
// ============================================================================
module usb_nrzi_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         low_speed,
  input  logic         pkt_start,
  usb_nrzi_tx_if.slave bus,
  output logic         d_plus_out,
  output logic         d_minus_out,
  output logic         tx_oe,
  output logic         busy,
  output logic         done,
  output logic         underrun
);

  localparam int EOP_MAX  = (EOP_SE0_BITS > EOP_J_BITS) ? EOP_SE0_BITS : EOP_J_BITS;
  localparam int SLOT_MAX = (EOP_MAX > 8) ? EOP_MAX : 8;
  localparam int BIT_CW   = $clog2(CLKS_PER_BIT);
  localparam int SLOT_CW  = $clog2(SLOT_MAX + 1);
  localparam int ONES_W   = $clog2(STUFF_LEN + 1);

  localparam logic [BIT_CW-1:0]  BIT_LAST = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [SLOT_CW-1:0] SE0_LAST = SLOT_CW'(EOP_SE0_BITS - 1);
  localparam logic [SLOT_CW-1:0] J_LAST   = SLOT_CW'(EOP_J_BITS - 1);
  localparam logic [ONES_W-1:0]  ONES_MAX = ONES_W'(STUFF_LEN);

  usb_tx_state_t      state, state_n;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [SLOT_CW-1:0] slot_cnt;
  logic [ONES_W-1:0]  ones, ones_n;
  logic               level, level_n;
  logic               sent_last, last_n;
  logic               pol, pol_n;
  logic               oe_n, done_n, under_n;
  logic               slot_end, stuff_due, ready;
  logic               go_data, tx_en, tx_bit, tx_stuff;
  logic [1:0]         line_n;

  flex_counter #(.NUM_CNT_BITS(BIT_CW)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state == IDLE),
    .count_enable (1'b1),
    .rollover_val (BIT_LAST),
    .count_out    (bit_cnt)
  );

  // Counts slots within the current state; restarts on every state change.
  flex_counter #(.NUM_CNT_BITS(SLOT_CW)) u_slot_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_n != state),
    .count_enable (slot_end),
    .rollover_val ({SLOT_CW{1'b1}}),
    .count_out    (slot_cnt)
  );

  assign slot_end      = (state == IDLE) ? pkt_start : (bit_cnt == BIT_LAST);
  assign stuff_due     = (ones == ONES_MAX);
  assign busy          = (state != IDLE);
  assign bus.bit_ready = ready;

  always_comb begin
    state_n  = state;
    level_n  = level;
    ones_n   = ones;
    last_n   = sent_last;
    pol_n    = pol;
    oe_n     = tx_oe;
    done_n   = 1'b0;
    under_n  = 1'b0;
    ready    = 1'b0;
    go_data  = 1'b0;
    tx_en    = 1'b0;
    tx_bit   = 1'b0;
    tx_stuff = 1'b0;
    if (slot_end) begin
      case (state)
        IDLE: begin
          pol_n = low_speed;
          oe_n  = 1'b1;
`ifdef USB_TX_SYNC_EN
          state_n = SYNC;
          tx_en   = 1'b1;
          tx_bit  = SYNC_PATTERN[7];
`else
          go_data = 1'b1;
`endif
        end
`ifdef USB_TX_SYNC_EN
        SYNC: begin
          if (slot_cnt[2:0] != 3'd7) begin
            tx_en  = 1'b1;
            tx_bit = SYNC_PATTERN[3'd6 - slot_cnt[2:0]];
          end else if (stuff_due) begin
            state_n  = STUFF;
            tx_stuff = 1'b1;
          end else begin
            go_data = 1'b1;
          end
        end
`endif
        DATA: begin
          if (stuff_due) begin
            state_n  = STUFF;
            tx_stuff = 1'b1;
          end else if (sent_last) begin
            state_n = EOP_SE0;
          end else begin
            go_data = 1'b1;
          end
        end
        STUFF: begin
          if (sent_last) state_n = EOP_SE0;
          else           go_data = 1'b1;
        end
        EOP_SE0: begin
          if (slot_cnt == SE0_LAST) state_n = EOP_J;
        end
        EOP_J: begin
          if (slot_cnt == J_LAST) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            done_n  = 1'b1;
            level_n = 1'b0;
            ones_n  = '0;
            last_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase

      // A missing bit at a data slot truncates the packet straight into EOP.
      if (go_data) begin
        ready = 1'b1;
        if (bus.bit_valid) begin
          state_n = DATA;
          tx_en   = 1'b1;
          tx_bit  = bus.bit_in;
          last_n  = bus.bit_last;
        end else begin
          state_n = EOP_SE0;
          under_n = 1'b1;
        end
      end

      if (tx_en) begin
        if (tx_bit) begin
          ones_n = ones + 1'b1;
        end else begin
          ones_n  = '0;
          level_n = ~level;
        end
      end
      if (tx_stuff) begin
        ones_n  = '0;
        level_n = ~level;
      end
    end
  end

  always_comb begin
    line_n = line_code(pol_n, level_n);
    if (state_n == EOP_SE0)                        line_n = LINE_SE0;
    else if (state_n == EOP_J || state_n == IDLE) line_n = line_code(pol_n, 1'b0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level                     <= 1'b0;
      ones                      <= '0;
      sent_last                 <= 1'b0;
      pol                       <= 1'b0;
      tx_oe                     <= 1'b0;
      done                      <= 1'b0;
      underrun                  <= 1'b0;
      {d_plus_out, d_minus_out} <= FS_J;
    end else begin
      level                     <= level_n;
      ones                      <= ones_n;
      sent_last                 <= last_n;
      pol                       <= pol_n;
      tx_oe                     <= oe_n;
      done                      <= done_n;
      underrun                  <= under_n;
      {d_plus_out, d_minus_out} <= line_n;
    end
  end

endmodule
`default_nettype wire

// File: doc/usb_nrzi_tx.md
# usb_nrzi_tx

Parametrised USB transmit line encoder for the host-side USB interface of the miner. It accepts a serial bit stream through a per-bit valid/ready handshake and times each bit with an internal bit-period counter. It applies NRZI encoding and configurable bit stuffing, and terminates each packet with a configurable SE0/J end-of-packet sequence. It sits between the packet serialiser and the D+/D- pad drivers, and supports full-speed and low-speed line polarity at run time.

## Interface
- CLKS_PER_BIT, 4, clock cycles per USB bit time (≥2)
- STUFF_LEN, 6, consecutive transmitted 1s that force a stuffed 0 (≥1)
- EOP_SE0_BITS, 2, EOP SE0 length in bit times (≥1)
- EOP_J_BITS, 1, J bit times driven after SE0 before release (≥1)
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- low_speed  in  1  1 = low-speed polarity (J: D+=0, D-=1); 0 = full-speed (J: D+=1, D-=0); sampled only in IDLE
- pkt_start  in  1  single-cycle request to begin a packet; ignored unless IDLE
- bit_in  in  1  next data bit
- bit_last  in  1  qualifies bit_in as the final data bit of the packet
- bit_valid  in  1  bit_in/bit_last are valid
- bit_ready  out  1  encoder consumes bit_in this cycle when bit_valid is also high
- d_plus_out  out  1  registered D+ drive
- d_minus_out  out  1  registered D- drive
- tx_oe  out  1  registered pad output enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the return to IDLE after a packet
- underrun  out  1  one-cycle pulse when bit_valid is low at a data slot

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- Reset/IDLE outputs:
  - Reset: line = full-speed J (d_plus_out=1, d_minus_out=0); tx_oe, busy, done, underrun = 0; all counters = 0.
  - In IDLE the line is J for the latched polarity.
- NRZI rule:
  - Data 0 toggles the line between J and K.
  - Data 1 holds the line.
  - The line level before the first bit is J.
- Slot boundary (slot_end):
  - Asserted on the last cycle of each bit slot (bit counter == CLKS_PER_BIT-1), and also in IDLE when pkt_start is high.
  - The next slot's level is registered on the clock edge that ends slot_end.
- IDLE -> SYNC on pkt_start (with USB_TX_SYNC_EN), otherwise IDLE -> DATA. Polarity is latched and tx_oe is set on the same edge.
- SYNC: transmits the 8 bits 0000_0001, giving KJKJKJKK. The final 1 counts toward the stuffing run. Goes to DATA after the 8th slot.
- bit_ready = slot_end && (the next slot is a DATA slot). It is combinational. A bit is accepted when bit_ready && bit_valid.
- Ones counter:
  - Increments on each transmitted 1.
  - Clears on any transmitted 0 or stuffed bit.
  - When it reaches STUFF_LEN, the next slot is STUFF: a forced 0 (toggle), with no bit_ready.
  - Afterwards the FSM returns to DATA, or to EOP_SE0 if the last bit has already been sent.
- bit_last accepted: after that slot, plus a STUFF slot if the run hits STUFF_LEN on the final bit, go to EOP_SE0.
- Underrun: bit_valid is low while bit_ready is high. Pulse underrun and go to EOP_SE0 at the next slot (packet truncated).
- EOP_SE0: D+ = D- = 0 for EOP_SE0_BITS slots.
- EOP_J: J for EOP_J_BITS slots. Then go to IDLE, clear tx_oe, and pulse done on that edge.
- pkt_start while busy: ignored, with no effect on the current packet.
- low_speed changes mid-packet: ignored until the next IDLE.

## Timing
- Latency: pkt_start at edge t. The first line bit (SYNC or data) is driven from edge t+1 and lasts CLKS_PER_BIT cycles.
- Each slot is exactly CLKS_PER_BIT cycles, and the line changes only at slot boundaries.
- bit_ready for the first data bit without SYNC is high in the pkt_start cycle itself.
- Packet length in slots = 8 (if SYNC) + N data bits + stuffed bits + EOP_SE0_BITS + EOP_J_BITS.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). The partial packet is dropped and no done pulse is generated.

## Configuration
- USB_TX_SYNC_EN defined: the SYNC state is compiled in, and the encoder prepends the 8-bit SYNC pattern to every packet.
- USB_TX_SYNC_EN undefined: there is no SYNC state, and the source supplies SYNC as ordinary data bits (stuffing applies to them).

## Structure
- Shared package usb_pkg:
  - state enum usb_tx_state_t
  - SYNC_PATTERN = 8'b0000_0001
  - polarity constants for J and K per speed
- One sub-module: the existing flex_counter, instantiated for the bit-period counter (rollover CLKS_PER_BIT) and the slot counter (SYNC/EOP lengths).
- The ones counter is kept inline.

## Test plan
- Defaults, full-speed, no SYNC, data 0,1,0 then last: line J→K,K,J, then SE0 for 8 cycles, J for 4 cycles, then done. tx_oe is high for 24 cycles.
- Data of seven 1s with last on the 7th: after 6 ones, a STUFF slot toggles with bit_ready low, then the 7th bit is sent. Total 8 data-phase slots.
- Six 1s with last on the 6th: a stuff slot is inserted before EOP_SE0.
- low_speed=1 with USB_TX_SYNC_EN: SYNC drives D+/D- as 1/0,0/1 alternating, ends K,K (D+=1, D-=0). Idle before and after is D+=0, D-=1.
- bit_valid dropped mid-packet: underrun pulses once, and EOP starts at the next slot boundary.
- n_rst asserted during EOP_SE0: outputs go to J immediately with tx_oe=0 and no done pulse. A subsequent pkt_start sends a normal packet.
